// File: rtl/vector_magnitude_seq_pkg.sv
// Shared types for the sequential magnitude engine: FSM state encoding and mode selectors.
package vector_magnitude_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SQUARE = 2'd1,
    S_ROOT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic MODE_HYPOT = 1'b0;
  localparam logic MODE_GMEAN = 1'b1;

endpackage

// File: rtl/vector_magnitude_seq_if.sv
// Operand/result handshake bundle between the pin mapping (master) and the engine (slave).
interface vector_magnitude_seq_if #(parameter int W = 8);

  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_root;
  logic         out_exact;

  modport master (
    output in_valid, in_mode, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_root, out_exact
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, out_ready,
    output in_ready, out_valid, out_root, out_exact
  );

endinterface

// File: rtl/vector_magnitude_seq_isqrt_step.sv
// One restoring square-root digit step: consumes two radicand bits, yields one root bit.
module isqrt_step #(
  parameter int RW = 9
) (
  input  logic [RW:0]   rem,
  input  logic [RW-1:0] root,
  input  logic [1:0]    pair,
  output logic [RW:0]   rem_next,
  output logic [RW-1:0] root_next
);

  logic [RW+2:0] rem_sh;
  logic [RW+2:0] trial;

  // rem never exceeds 2*root, so the post-step remainder always fits RW+1 bits
  // and the subtraction can be done modulo 2^(RW+1).
  always_comb begin
    rem_sh = {rem, pair};
    trial  = {1'b0, root, 2'b01};
    if (rem_sh >= trial) begin
      rem_next  = rem_sh[RW:0] - trial[RW:0];
      root_next = {root[RW-2:0], 1'b1};
    end else begin
      rem_next  = rem_sh[RW:0];
      root_next = {root[RW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/vector_magnitude_seq.sv
// Multi-cycle floor(sqrt(x*x+y*y)) / floor(sqrt(x*y)) engine with valid/ready on both sides.
//   state    | meaning
//   S_IDLE   | ready for operands; last result held on the outputs
//   S_SQUARE | form the radicand from the latched magnitudes
//   S_ROOT   | W+1 digit steps, counter runs W..0
//   S_DONE   | result valid, waiting for out_ready
module vector_magnitude_seq
  import vector_magnitude_pkg::*;
#(
  parameter int W         = 8,
  parameter bit SIGNED_IN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  vector_magnitude_seq_if.slave bus
);

  localparam int RW   = W + 1;
  localparam int RADW = 2 * W + 2;
  localparam int CW   = $clog2(W + 1);

  state_t          state, state_next;
  logic [W-1:0]    a, b;
  logic            mode;
  logic [RADW-1:0] rad;
  logic [RW:0]     rem;
  logic [RW-1:0]   root;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   root_q;
  logic            exact_q;

  logic [W-1:0]    abs_x, abs_y;
  logic [RADW-1:0] a_ext, b_ext, sq_sum, prod;
  logic [RW:0]     rem_step;
  logic [RW-1:0]   root_step;

  always_comb begin
    abs_x = (SIGNED_IN && bus.in_x[W-1]) ? (~bus.in_x + 1'b1) : bus.in_x;
    abs_y = (SIGNED_IN && bus.in_y[W-1]) ? (~bus.in_y + 1'b1) : bus.in_y;
  end

  always_comb begin
    a_ext  = RADW'(a);
    b_ext  = RADW'(b);
    sq_sum = a_ext * a_ext + b_ext * b_ext;
    prod   = a_ext * b_ext;
  end

  // Radicand is shifted left each step, so its top pair is always the next to consume.
  isqrt_step #(.RW(RW)) u_step (
    .rem       (rem),
    .root      (root),
    .pair      (rad[RADW-1 -: 2]),
    .rem_next  (rem_step),
    .root_next (root_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bus.in_valid) state_next = S_SQUARE;
      S_SQUARE: state_next = S_ROOT;
      S_ROOT:   if (cnt == '0) state_next = S_DONE;
      S_DONE:   if (bus.out_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      mode    <= MODE_HYPOT;
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      root_q  <= '0;
      exact_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a    <= abs_x;
            b    <= abs_y;
            mode <= bus.in_mode;
          end
        end
        S_SQUARE: begin
          rad  <= (mode == MODE_GMEAN) ? prod : sq_sum;
          rem  <= '0;
          root <= '0;
          cnt  <= CW'(W);
        end
        S_ROOT: begin
          rad  <= rad << 2;
          rem  <= rem_step;
          root <= root_step;
          if (cnt == '0) begin
            root_q  <= root_step;
            exact_q <= (rem_step == '0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_root  = root_q;
  assign bus.out_exact = exact_q;

endmodule

// File: tb/tb_vector_magnitude_seq.sv
// Drives an unsigned and a signed engine with identical operands and checks both against a reference.
module tb_vector_magnitude_seq;
  import vector_magnitude_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;

  always #5 clk = ~clk;

  vector_magnitude_seq_if #(.W(W)) bu ();
  vector_magnitude_seq_if #(.W(W)) bs ();

  assign bu.in_valid  = in_valid;
  assign bu.in_mode   = in_mode;
  assign bu.in_x      = in_x;
  assign bu.in_y      = in_y;
  assign bu.out_ready = out_ready;
  assign bs.in_valid  = in_valid;
  assign bs.in_mode   = in_mode;
  assign bs.in_x      = in_x;
  assign bs.in_y      = in_y;
  assign bs.out_ready = out_ready;

  vector_magnitude_seq #(.W(W), .SIGNED_IN(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(bu));
  vector_magnitude_seq #(.W(W), .SIGNED_IN(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bs));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic straight from the definition.
  function automatic longint isqrt_ref(input longint n);
    longint r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic longint mag(input logic [7:0] v, input bit sgn);
    if (sgn && v[7]) return 256 - longint'(v);
    return longint'(v);
  endfunction

  function automatic longint radicand(input bit m, input longint p, input longint q);
    return (m == MODE_GMEAN) ? p * q : p * p + q * q;
  endfunction

  typedef struct {
    bit         m;
    logic [7:0] x;
    logic [7:0] y;
    int         ru;
    bit         eu;
    int         rs;
    bit         es;
  } vec_t;

  vec_t vecs[11];

  task automatic run_op(input bit m, input logic [7:0] x, input logic [7:0] y, input bit early,
                        output int lat, output logic [8:0] ru, output logic eu,
                        output logic [8:0] rs, output logic es);
    @(negedge clk);
    in_valid  = 1'b1;
    in_mode   = m;
    in_x      = x;
    in_y      = y;
    out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x     = 8'($urandom);
    in_y     = 8'($urandom);
    lat      = 0;
    while (!(bu.out_valid && bs.out_valid) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ru = bu.out_root;
    eu = bu.out_exact;
    rs = bs.out_root;
    es = bs.out_exact;
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int         lat;
    logic [8:0] ru, rs;
    logic       eu, es;
    bit         ok;
    int         extra;

    vecs[0]  = '{MODE_HYPOT, 8'd3,   8'd4,   5,   1'b1, 5,   1'b1};
    vecs[1]  = '{MODE_HYPOT, 8'd255, 8'd255, 360, 1'b0, 1,   1'b0};
    vecs[2]  = '{MODE_HYPOT, 8'd7,   8'd24,  25,  1'b1, 25,  1'b1};
    vecs[3]  = '{MODE_GMEAN, 8'd4,   8'd9,   6,   1'b1, 6,   1'b1};
    vecs[4]  = '{MODE_GMEAN, 8'd1,   8'd0,   0,   1'b1, 0,   1'b1};
    vecs[5]  = '{MODE_GMEAN, 8'd200, 8'd3,   24,  1'b0, 12,  1'b0};
    vecs[6]  = '{MODE_HYPOT, 8'd253, 8'd4,   253, 1'b0, 5,   1'b1};
    vecs[7]  = '{MODE_HYPOT, 8'd128, 8'd128, 181, 1'b0, 181, 1'b0};
    vecs[8]  = '{MODE_HYPOT, 8'd0,   8'd0,   0,   1'b1, 0,   1'b1};
    vecs[9]  = '{MODE_GMEAN, 8'd255, 8'd255, 255, 1'b1, 1,   1'b1};
    vecs[10] = '{MODE_HYPOT, 8'd5,   8'd12,  13,  1'b1, 13,  1'b1};

    #2 rst = 1'b1;
    #1;
    check("reset_in_ready",  32'(bu.in_ready & bs.in_ready), 1);
    check("reset_out_valid", 32'(bu.out_valid | bs.out_valid), 0);
    check("reset_out_root",  32'(bu.out_root | bs.out_root), 0);
    check("reset_out_exact", 32'(bu.out_exact | bs.out_exact), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].m, vecs[i].x, vecs[i].y, 1'b0, lat, ru, eu, rs, es);
      check($sformatf("vec%0d_latency", i), 32'(lat), 10);
      check($sformatf("vec%0d_root_u", i), 32'(ru), 32'(vecs[i].ru));
      check($sformatf("vec%0d_exact_u", i), 32'(eu), 32'(vecs[i].eu));
      check($sformatf("vec%0d_root_s", i), 32'(rs), 32'(vecs[i].rs));
      check($sformatf("vec%0d_exact_s", i), 32'(es), 32'(vecs[i].es));
      finish_op();
      check($sformatf("vec%0d_back_idle", i),
            32'(bu.in_ready & bs.in_ready & ~bu.out_valid & ~bs.out_valid), 1);
    end

    // Backpressure: DONE held for 20 cycles with frozen outputs.
    run_op(MODE_HYPOT, 8'd3, 8'd4, 1'b0, lat, ru, eu, rs, es);
    check("bp_latency", 32'(lat), 10);
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!(bu.out_valid && bu.out_root == 9'd5 && bu.out_exact && !bu.in_ready)) ok = 1'b0;
    end
    check("bp_hold", 32'(ok), 1);
    finish_op();
    check("bp_release_ready", 32'(bu.in_ready), 1);
    check("bp_release_valid", 32'(bu.out_valid), 0);
    check("bp_idle_root_held", 32'(bu.out_root), 5);

    // Operands offered while busy are ignored.
    @(negedge clk);
    in_valid = 1'b1; in_mode = MODE_HYPOT; in_x = 8'd7; in_y = 8'd24;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'd1; in_y = 8'd1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!bu.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("busy_ignore_root", 32'(bu.out_root), 25);
    finish_op();
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bu.out_valid || bs.out_valid) extra++;
    end
    check("busy_no_extra_result", 32'(extra), 0);

    // Reset in the middle of the root recurrence.
    @(negedge clk);
    in_valid = 1'b1; in_mode = MODE_HYPOT; in_x = 8'd255; in_y = 8'd255;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(bu.in_ready & bs.in_ready), 1);
    check("midrst_out_valid", 32'(bu.out_valid | bs.out_valid), 0);
    check("midrst_out_root", 32'(bu.out_root), 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bu.out_valid || bs.out_valid) extra++;
    end
    check("midrst_no_pulse", 32'(extra), 0);
    run_op(MODE_HYPOT, 8'd5, 8'd12, 1'b0, lat, ru, eu, rs, es);
    check("postrst_latency", 32'(lat), 10);
    check("postrst_root", 32'(ru), 13);
    check("postrst_exact", 32'(eu), 1);
    finish_op();

    // Randomized operands against the reference; out_ready sometimes held high early.
    for (int n = 0; n < 40; n++) begin
      bit         m;
      logic [7:0] x, y;
      bit         early;
      longint     r_u, r_s;
      m     = 1'($urandom);
      x     = 8'($urandom_range(0, 255));
      y     = 8'($urandom_range(0, 255));
      early = 1'($urandom);
      r_u   = radicand(m, mag(x, 1'b0), mag(y, 1'b0));
      r_s   = radicand(m, mag(x, 1'b1), mag(y, 1'b1));
      run_op(m, x, y, early, lat, ru, eu, rs, es);
      check($sformatf("rnd%0d_latency", n), 32'(lat), 10);
      check($sformatf("rnd%0d_root_u m=%0d x=%0d y=%0d", n, m, x, y), 32'(ru), 32'(isqrt_ref(r_u)));
      check($sformatf("rnd%0d_exact_u", n), 32'(eu),
            32'(isqrt_ref(r_u) * isqrt_ref(r_u) == r_u));
      check($sformatf("rnd%0d_root_s m=%0d x=%0d y=%0d", n, m, x, y), 32'(rs), 32'(isqrt_ref(r_s)));
      check($sformatf("rnd%0d_exact_s", n), 32'(es),
            32'(isqrt_ref(r_s) * isqrt_ref(r_s) == r_s));
      finish_op();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
